// File: rtl/doodle_pkg.sv
// Shared constants and types for the doodle game blocks (motion, collision observer).
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package doodle_pkg;

  // Screen geometry; every coordinate in the game fits in COORD_W bits
  localparam int SCREEN_H = 1024;
  localparam int COORD_W  = $clog2(SCREEN_H);

  // Playfield landmarks (y grows downward)
  localparam int EARTH       = 700;
  localparam int DOODLE_H    = 80;
  localparam int SCROLL_LINE = 420;
  localparam int DEATH_Y     = 760;

  // Motion tuning
  localparam int JUMP_V      = 20;
  localparam int V_MAX       = 24;
  localparam int GRAV_DIV    = 2;
  localparam int SCROLL_STEP = 8;

  localparam int V_W = 6;
  localparam int G_W = 4;

  typedef enum logic [1:0] {
    RISE = 2'd0,
    FALL = 2'd1,
    DEAD = 2'd2
  } motion_state_t;

  // a - b, clamped at 0
  function automatic logic [COORD_W-1:0] sat_sub(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    logic [COORD_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[COORD_W] ? '0 : d[COORD_W-1:0];
  endfunction

  // a + b, clamped at the largest coordinate
  function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    logic [COORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COORD_W] ? '1 : s[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/doodle_vertical_motion_if.sv
// Bundle between the collision observer / frame timing and the vertical motion engine.
// Latency: n/a (wiring only).
// Backpressure: none; the motion engine consumes inputs only on frame_tick.
interface doodle_vertical_motion_if;
  import doodle_pkg::*;

  logic                         frame_tick;
  logic                         doodle_collision;
  logic                         move_collision;
  logic [1:0][COORD_W-1:0]      ground;
  logic [COORD_W-1:0]           doodle_y;
  logic                         doodle_fall_direction;
  logic [COORD_W-1:0]           scroll_px;
  logic                         scroll_valid;
  logic                         game_over;

  modport master (
    output frame_tick, doodle_collision, move_collision, ground,
    input  doodle_y, doodle_fall_direction, scroll_px, scroll_valid, game_over
  );

  modport slave (
    input  frame_tick, doodle_collision, move_collision, ground,
    output doodle_y, doodle_fall_direction, scroll_px, scroll_valid, game_over
  );

endinterface

// File: rtl/doodle_vertical_motion_scroll_stepper.sv
// Scroll remainder counter: emits at most SCROLL_STEP px per tick until the remainder is drained.
// Latency: step_px/step_en combinational on tick; scroll_px/scroll_valid registered, one cycle later.
// Backpressure: none; a new load discards any remainder still pending.
module scroll_stepper
  import doodle_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load,
  input  logic [COORD_W-1:0] load_px,
  output logic               step_en,
  output logic [COORD_W-1:0] step_px,
  output logic [COORD_W-1:0] scroll_px,
  output logic               scroll_valid
);

  localparam logic [COORD_W-1:0] STEP = COORD_W'(SCROLL_STEP);

  logic [COORD_W-1:0] rem_q;

  // A loading tick only arms the remainder; emission starts on the following tick
  always_comb begin
    step_en = tick && !load && (rem_q != '0);
    step_px = '0;
    if (step_en) begin
      step_px = (rem_q > STEP) ? STEP : rem_q;
    end
  end

  // Remainder, last emitted amount and the one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q        <= '0;
      scroll_px    <= '0;
      scroll_valid <= 1'b0;
    end else begin
      scroll_valid <= step_en;
      if (load) begin
        rem_q <= load_px;
      end else if (step_en) begin
        rem_q <= rem_q - step_px;
      end
      if (step_en) begin
        scroll_px <= step_px;
      end
    end
  end

endmodule

// File: rtl/doodle_vertical_motion.sv
// Per-frame vertical physics for the doodle: rise/fall integration, relaunch on landing, death, scroll offset.
// Latency: all outputs registered, valid the cycle after frame_tick.
// Backpressure: none; inputs are sampled only on frame_tick and ignored in between.
module doodle_vertical_motion
  import doodle_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  doodle_vertical_motion_if.slave bus
);

  motion_state_t      state_q, state_phys, state_d;
  logic [COORD_W-1:0] y_q, y_phys, y_d;
  logic [V_W-1:0]     v_q, v_d;
  logic [G_W-1:0]     g_q, g_d, g_inc;
  logic               g_wrap;
  logic               fall_q, fall_d;
  logic               over_q, over_d;
  logic               landing;

  logic               step_tick, load, step_en;
  logic [COORD_W-1:0] load_px, step_px, scroll_px;
  logic               scroll_valid;

  logic [COORD_W-1:0] ground_y;
  logic               ground_x_unused;

  assign ground_y        = bus.ground[0];
  assign ground_x_unused = ^bus.ground[1];

  assign g_wrap = (g_q == G_W'(GRAV_DIV - 1));
  assign g_inc  = g_wrap ? '0 : g_q + G_W'(1);

  // Physics step: integrate velocity/gravity or relaunch on a landing
  always_comb begin
    state_phys = state_q;
    y_phys     = y_q;
    v_d        = v_q;
    g_d        = g_q;
    fall_d     = fall_q;
    landing    = 1'b0;
    if (bus.frame_tick) begin
      unique case (state_q)
        RISE: begin
          y_phys = sat_sub(y_q, COORD_W'(v_q));
          g_d    = g_inc;
          if (g_wrap) begin
            v_d = v_q - V_W'(1);
          end
          if (v_d == '0) begin
            state_phys = FALL;
            fall_d     = 1'b1;
            g_d        = '0;
          end
        end
        FALL: begin
          if (bus.doodle_collision) begin
            landing    = 1'b1;
            y_phys     = sat_sub(ground_y, COORD_W'(DOODLE_H));
            v_d        = V_W'(JUMP_V);
            g_d        = '0;
            state_phys = RISE;
            fall_d     = 1'b0;
          end else begin
            y_phys = sat_add(y_q, COORD_W'(v_q));
            g_d    = g_inc;
            if (g_wrap) begin
              v_d = (v_q >= V_W'(V_MAX)) ? V_W'(V_MAX) : v_q + V_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Scroll offset goes on top of the physics result; death is judged on the final y
  always_comb begin
    y_d     = y_phys;
    state_d = state_phys;
    over_d  = over_q;
    if (step_en) begin
      y_d = sat_add(y_phys, step_px);
    end
    if (bus.frame_tick && (state_q == FALL) && !landing && (y_d >= COORD_W'(DEATH_Y))) begin
      state_d = DEAD;
      over_d  = 1'b1;
    end
  end

  assign step_tick = bus.frame_tick && (state_q != DEAD);
  assign load      = landing && bus.move_collision;
  assign load_px   = sat_sub(COORD_W'(SCROLL_LINE), ground_y);

  scroll_stepper u_scroll (
    .clk          (clk),
    .rst          (rst),
    .tick         (step_tick),
    .load         (load),
    .load_px      (load_px),
    .step_en      (step_en),
    .step_px      (step_px),
    .scroll_px    (scroll_px),
    .scroll_valid (scroll_valid)
  );

  // Motion state register; reset leaves the doodle standing on the floor, falling
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FALL;
    end else begin
      state_q <= state_d;
    end
  end

  // Position, velocity, gravity phase and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= COORD_W'(EARTH - DOODLE_H);
      v_q    <= '0;
      g_q    <= '0;
      fall_q <= 1'b1;
      over_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      v_q    <= v_d;
      g_q    <= g_d;
      fall_q <= fall_d;
      over_q <= over_d;
    end
  end

  assign bus.doodle_y              = y_q;
  assign bus.doodle_fall_direction = fall_q;
  assign bus.scroll_px             = scroll_px;
  assign bus.scroll_valid          = scroll_valid;
  assign bus.game_over             = over_q;

endmodule

// File: tb/tb_doodle_vertical_motion.sv
module tb_doodle_vertical_motion;
  import doodle_pkg::*;

  logic clk = 1'b0;
  logic rst;

  doodle_vertical_motion_if bus ();

  doodle_vertical_motion dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    bit fall;
    bit vld;
    int px;
    bit over;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  logic  probe  = 1'b0;
  logic  due    = 1'b0;
  int    tick_no = 0;

  // reference model of the doodle, in plain integers
  int m_y, m_v, m_g, m_state, m_r, m_px;
  bit m_fall, m_valid, m_over;

  task automatic model_reset();
    m_y = 620; m_v = 0; m_g = 0; m_state = 1; m_r = 0; m_px = 0;
    m_fall = 1; m_valid = 0; m_over = 0;
  endtask

  task automatic model_tick(input bit coll, input bit move, input int g0);
    bit land;
    bit was_fall;
    int s;
    land = 0;
    was_fall = (m_state == 1);
    m_valid = 0;
    if (m_state != 2) begin
      if (m_state == 0) begin
        m_y = (m_y - m_v < 0) ? 0 : m_y - m_v;
        if (m_g == GRAV_DIV - 1) begin m_g = 0; m_v = m_v - 1; end
        else m_g = m_g + 1;
        if (m_v == 0) begin m_state = 1; m_fall = 1; m_g = 0; end
      end else if (coll) begin
        land = 1;
        m_y = (g0 - 80 < 0) ? 0 : g0 - 80;
        m_v = 20; m_g = 0; m_state = 0; m_fall = 0;
      end else begin
        m_y = (m_y + m_v > 1023) ? 1023 : m_y + m_v;
        if (m_g == GRAV_DIV - 1) begin m_g = 0; if (m_v < 24) m_v = m_v + 1; end
        else m_g = m_g + 1;
      end
      if (land && move) begin
        m_r = (420 - g0 < 0) ? 0 : 420 - g0;
      end else if (m_r > 0) begin
        s = (m_r < 8) ? m_r : 8;
        m_px = s; m_valid = 1; m_r = m_r - s;
        m_y = (m_y + s > 1023) ? 1023 : m_y + s;
      end
      if (was_fall && !land && m_y >= 760) begin m_state = 2; m_over = 1; end
    end
  endtask

  task automatic push(input string name, input int y, input bit fall, input bit vld,
                      input int px, input bit over);
    exp_t e;
    e.y = y; e.fall = fall; e.vld = vld; e.px = px; e.over = over;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit coll, input bit move, input int g0);
    bus.frame_tick       = 1'b1;
    bus.doodle_collision = coll;
    bus.move_collision   = move;
    bus.ground[0]        = 10'(g0);
    model_tick(coll, move, g0);
    tick_no++;
    push($sformatf("tick%0d", tick_no), m_y, m_fall, m_valid, m_px, m_over);
    cyc();
    bus.frame_tick       = 1'b0;
    bus.doodle_collision = 1'b0;
    bus.move_collision   = 1'b0;
    cyc();
    cyc();
  endtask

  // hand-computed snapshot of the outputs, taken with no tick
  task automatic check_now(input string name, input int y, input bit fall, input bit vld,
                           input int px, input bit over);
    push(name, y, fall, vld, px, over);
    probe = 1'b1;
    cyc();
    probe = 1'b0;
    cyc();
  endtask

  // Scoreboard monitor
  always @(posedge clk) due <= bus.frame_tick | probe;

  exp_t  mon_e;
  string mon_n;
  always @(negedge clk) begin
    if (due) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: y=%0d with no expectation queued", bus.doodle_y);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if (int'(bus.doodle_y) != mon_e.y || bus.doodle_fall_direction !== mon_e.fall ||
            bus.scroll_valid !== mon_e.vld || int'(bus.scroll_px) != mon_e.px ||
            bus.game_over !== mon_e.over) begin
          errors++;
          $display("FAIL %s: got y=%0d fall=%b vld=%b px=%0d over=%b, want y=%0d fall=%b vld=%b px=%0d over=%b",
                   mon_n, bus.doodle_y, bus.doodle_fall_direction, bus.scroll_valid, bus.scroll_px,
                   bus.game_over, mon_e.y, mon_e.fall, mon_e.vld, mon_e.px, mon_e.over);
        end
      end
    end else if (!rst) begin
      checks++;
      if (bus.scroll_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_scroll_valid: got %b want 0", bus.scroll_valid);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.frame_tick = 1'b0; bus.doodle_collision = 1'b0; bus.move_collision = 1'b0;
    bus.ground[0] = 10'd0; bus.ground[1] = 10'd123;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    check_now("reset", 620, 1, 0, 0, 0);

    // floor landing relaunches immediately
    tick(1, 0, 700);
    check_now("launch", 620, 0, 0, 0, 0);

    // full rise, with collisions during RISE that must be ignored
    for (int i = 0; i < 40; i++) tick((i == 2 || i == 3), 1, 300);
    check_now("apex", 200, 1, 0, 0, 0);

    // collision pulses without a frame tick
    bus.doodle_collision = 1'b1; bus.ground[0] = 10'd300; bus.move_collision = 1'b1;
    repeat (3) cyc();
    bus.doodle_collision = 1'b0; bus.move_collision = 1'b0;
    check_now("no_tick_collision", 200, 1, 0, 0, 0);

    // short fall, then a scroll-qualifying landing
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    tick(1, 1, 300);
    check_now("land_300", 220, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick(0, 0, 0);
    check_now("scroll_done", 89, 0, 0, 8, 0);
    tick(0, 0, 0);
    check_now("after_scroll", 76, 0, 0, 8, 0);

    // finish the rise, land at the top of the screen
    for (int i = 0; i < 60 && m_fall == 0; i++) tick(0, 0, 0);
    tick(1, 0, 80);
    check_now("land_80", 0, 0, 0, 8, 0);
    for (int i = 0; i < 40; i++) tick(0, 0, 0);
    check_now("top_apex", 0, 1, 0, 8, 0);

    // free fall into velocity saturation and death
    for (int i = 0; i < 48; i++) tick(0, 0, 0);
    check_now("v_max_reached", 552, 1, 0, 8, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 0);
    check_now("v_saturated", 744, 1, 0, 8, 0);
    tick(0, 0, 0);
    check_now("death", 768, 1, 0, 8, 1);
    for (int i = 0; i < 3; i++) tick(1, 1, 700);
    check_now("dead_hold", 768, 1, 0, 8, 1);

    // reset out of DEAD
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    check_now("reset_from_dead", 620, 1, 0, 0, 0);
    tick(1, 0, 700);
    check_now("relaunch", 620, 0, 0, 0, 0);

    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drained: got %0d expectations left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/doodle_vertical_motion.md
# doodle_vertical_motion

Frame-rate vertical physics engine for the doodle: integrates velocity and gravity, produces `doodle_y` and `doodle_fall_direction`, and re-launches the doodle on landing. It sits directly downstream of the collision observer, consuming its `doodle_collision`, `move_collision` and `ground` outputs. It feeds `doodle_y` and fall direction back to that observer, and drives world-scroll requests to the platform manager.

## Interface
- `EARTH`, 700: screen y of the floor line (y grows downward).
- `DOODLE_H`, 80: doodle sprite height; landing snaps `y = ground_y - DOODLE_H`.
- `JUMP_V`, 20: launch velocity, px/frame.
- `V_MAX`, 24: fall velocity saturation, px/frame.
- `GRAV_DIV`, 2: frames per 1 px/frame velocity change (≥1).
- `SCROLL_LINE`, 420: landings with platform y above this line trigger scroll.
- `SCROLL_STEP`, 8: maximum scroll px emitted per frame.
- `DEATH_Y`, 760: falling doodle with `y ≥ DEATH_Y` dies.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `doodle_collision` in 1: landing/floor contact from the collision observer.
- `move_collision` in 1: landing qualifies for scroll.
- `ground` in [1:0][9:0]: landed platform; `[0]` = top y, `[1]` = x (unused here).
- `doodle_y` out 10: doodle top y, unsigned.
- `doodle_fall_direction` out 1: 1 = falling, 0 = rising.
- `scroll_px` out 10: scroll amount for this frame.
- `scroll_valid` out 1: one-cycle pulse accompanying `scroll_px`.
- `game_over` out 1: sticky death flag.

## Operation
- States: RISE, FALL, DEAD. Velocity `v` is unsigned 6-bit. Gravity counter `g` counts 0..GRAV_DIV-1.
- All updates happen only in the cycle where `frame_tick = 1`. Otherwise registers hold.
- RISE: `y ← sat0(y - v)`. When `g` wraps, `v ← v - 1`. When `v` reaches 0 (the next value is 0): go to FALL, `doodle_fall_direction ← 1`, `g ← 0`.
- FALL, no collision: `y ← sat1023(y + v)`. When `g` wraps, `v ← min(v + 1, V_MAX)`.
- FALL with `doodle_collision = 1` on the tick: `y ← sat0(ground[0] - DOODLE_H)`, `v ← JUMP_V`, `g ← 0`, go to RISE, fall_dir ← 0. Collision wins over the death check and over integration.
- Landing with `move_collision = 1`: load scroll remainder `r ← SCROLL_LINE - ground[0]` (saturate at 0).
- Scroll runs independently of state. On each tick with `r > 0`: `s = min(r, SCROLL_STEP)`, `scroll_px ← s`, `scroll_valid ← 1`, `r ← r - s`, and `y ← y + s` added after the physics update, saturating.
- A new landing while `r > 0` reloads `r`; the old remainder is discarded.
- FALL with `y ≥ DEATH_Y` after the update: go to DEAD, `game_over ← 1`. DEAD holds all outputs until `rst`.
- `doodle_collision` in RISE is ignored.

## Timing
- Reset values: `doodle_y = EARTH - DOODLE_H`, fall_dir = 1, state FALL, `v = 0`, `g = 0`, `r = 0`, `scroll_px = 0`, `scroll_valid = 0`, `game_over = 0`.
- The floor collision therefore relaunches the doodle on the first tick after reset.
- Outputs are registered and update the cycle after `frame_tick`.
- `scroll_valid` is high for exactly one cycle per emitting tick. `scroll_px` holds its last value otherwise.
- Inputs are sampled only in the tick cycle. The observer's one-cycle registered latency is absorbed because the tick spacing is far greater than one cycle.
- `rst` mid-scroll or in DEAD clears everything to reset values in the next cycle.

## Structure
- `doodle_pkg`: `DOODLE_H`, `EARTH`, `SCROLL_LINE`, screen-size constants, and the `motion_state_t` enum {RISE, FALL, DEAD}. The collision observer shares these.
- One sub-module, `scroll_stepper`, holding the remainder counter, step clamp and `scroll_valid` pulse. The state machine and integration stay in the top.

## Test plan
- Reset, then 1 tick with `doodle_collision = 1`, `ground[0] = 700`: the response is `y = 620`, RISE, `v = 20`. Rise over 40 ticks (GRAV_DIV = 2), then fall_dir = 1.
- Falling at `v = 24`: 10 further ticks keep `v = 24`, and `y` increases by 24 each tick.
- Land with `ground[0] = 300`, `move_collision = 1`: `r = 120`. The next 15 ticks give `scroll_px = 8` with a `scroll_valid` pulse each, then nothing. `y` includes the +8 offsets.
- Collision asserted during RISE: ignored, and `v` and `y` follow the free trajectory.
- Fall with no collision past `y = 760`: `game_over = 1`, DEAD. Further ticks and collisions leave outputs unchanged. `rst` restores `y = 620` and FALL.
- Collision pulses between ticks (no `frame_tick`): no state change.
